// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache controller slice.
package dcache_pkg;

    localparam int STAT_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_RD   = 3'd2,
        MEM_WAIT = 3'd3,
        FILL     = 3'd4,
        WR_CACHE = 3'd5,
        MEM_WR   = 3'd6,
        RESP     = 3'd7
    } state_t;

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU, cache-array and DRAM signals of dcache_ctrl; master = controller side, slave = environment side.
interface dcache_ctrl_if #(
    parameter int IDX_W  = 8,
    parameter int TAG_W  = 8,
    parameter int DATA_W = 32
);
    localparam int ADDR_W = TAG_W + IDX_W;
    localparam int LINE_W = TAG_W + DATA_W + 1;

    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic              cpu_req_we;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [DATA_W-1:0] cpu_req_wdata;
    logic              cpu_rsp_valid;
    logic [DATA_W-1:0] cpu_rsp_rdata;
    logic              cache_enable;
    logic              rd_wr_sel;
    logic [IDX_W-1:0]  index_sel;
    logic [LINE_W-1:0] write_index;
    logic              cache_valid;
    logic [TAG_W-1:0]  cache_tag;
    logic [DATA_W-1:0] cache_data_io;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_rdata;

    modport master (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
        output cache_enable, rd_wr_sel, index_sel, write_index,
        input  cache_valid, cache_tag, cache_data_io,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
        input  cache_enable, rd_wr_sel, index_sel, write_index,
        output cache_valid, cache_tag, cache_data_io,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

endinterface

// File: rtl/dcache_stat_ctr.sv
// Saturating event counter used for the optional hit/miss statistics.
module dcache_stat_ctr
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [STAT_W-1:0] count
);

    logic [STAT_W-1:0] count_r;

    // Count up on inc, holding at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (inc && (count_r != {STAT_W{1'b1}})) begin
            count_r <= count_r + STAT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/dcache_ctrl.sv
// Write-through, write-allocate data-cache controller in front of a one-word-per-line array.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_COUNT = 256,
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 8
) (
    input  logic clk,
    input  logic rst,
    dcache_ctrl_if.master bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
`endif
);

    localparam int IDX_W  = $clog2(INDEX_COUNT);
    localparam int ADDR_W = TAG_W + IDX_W;
    localparam int LINE_W = TAG_W + DATA_W + 1;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic              we_r, we_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic [DATA_W-1:0] rdata_r, rdata_s;
    logic              accept_s, hit_s;

    logic              ready_r, ready_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;
    logic              cache_en_r, cache_en_s;
    logic [IDX_W-1:0]  index_r, index_s;
    logic [LINE_W-1:0] line_r, line_s;
    logic              mem_valid_r, mem_valid_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;

    assign accept_s = bus.cpu_req_valid && ready_r;
    assign hit_s    = bus.cache_valid && (bus.cache_tag == addr_r[ADDR_W-1:IDX_W]);

    // Next state and request/data latch updates
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        we_s    = we_r;
        wdata_s = wdata_r;
        rdata_s = rdata_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = LOOKUP;
                    addr_s  = bus.cpu_req_addr;
                    we_s    = bus.cpu_req_we;
                    wdata_s = bus.cpu_req_wdata;
                    rdata_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            LOOKUP: begin
                if (we_r) begin
                    state_s = WR_CACHE;
                end else if (hit_s) begin
                    state_s = RESP;
                    rdata_s = bus.cache_data_io;
                end else begin
                    state_s = MEM_RD;
                end
            end
            MEM_RD: begin
                if (bus.mem_req_ready) state_s = MEM_WAIT;
                else                   state_s = MEM_RD;
            end
            MEM_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_s = FILL;
                    rdata_s = bus.mem_rsp_rdata;
                end else begin
                    state_s = MEM_WAIT;
                end
            end
            FILL:     state_s = RESP;
            WR_CACHE: state_s = MEM_WR;
            MEM_WR: begin
                if (bus.mem_req_ready) state_s = RESP;
                else                   state_s = MEM_WR;
            end
            RESP:     state_s = IDLE;
            default:  state_s = IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so they can be registered without extra latency
    always_comb begin
        ready_s     = 1'b0;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = '0;
        cache_en_s  = 1'b0;
        index_s     = addr_s[IDX_W-1:0];
        line_s      = '0;
        mem_valid_s = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        case (state_s)
            IDLE: begin
                ready_s = 1'b1;
                index_s = '0;
            end
            MEM_RD: begin
                mem_valid_s = 1'b1;
                mem_addr_s  = addr_s;
            end
            FILL: begin
                cache_en_s = 1'b1;
                line_s     = {1'b1, addr_s[ADDR_W-1:IDX_W], rdata_s};
            end
            WR_CACHE: begin
                cache_en_s = 1'b1;
                line_s     = {1'b1, addr_s[ADDR_W-1:IDX_W], wdata_s};
            end
            MEM_WR: begin
                mem_valid_s = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = addr_s;
                mem_wdata_s = wdata_s;
            end
            RESP: begin
                rsp_valid_s = 1'b1;
                if (we_s) rsp_rdata_s = '0;
                else      rsp_rdata_s = rdata_s;
            end
            default: begin
                index_s = addr_s[IDX_W-1:0];
            end
        endcase
    end

    // State, latch and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            addr_r      <= '0;
            we_r        <= 1'b0;
            wdata_r     <= '0;
            rdata_r     <= '0;
            ready_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            cache_en_r  <= 1'b0;
            index_r     <= '0;
            line_r      <= '0;
            mem_valid_r <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            we_r        <= we_s;
            wdata_r     <= wdata_s;
            rdata_r     <= rdata_s;
            ready_r     <= ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            cache_en_r  <= cache_en_s;
            index_r     <= index_s;
            line_r      <= line_s;
            mem_valid_r <= mem_valid_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    assign bus.cpu_req_ready = ready_r;
    assign bus.cpu_rsp_valid = rsp_valid_r;
    assign bus.cpu_rsp_rdata = rsp_rdata_r;
    assign bus.cache_enable  = cache_en_r;
    // The array is only ever enabled to write, so the select tracks the enable
    assign bus.rd_wr_sel     = cache_en_r;
    assign bus.index_sel     = index_r;
    assign bus.write_index   = line_r;
    assign bus.mem_req_valid = mem_valid_r;
    assign bus.mem_req_we    = mem_we_r;
    assign bus.mem_req_addr  = mem_addr_r;
    assign bus.mem_req_wdata = mem_wdata_r;

`ifdef DCACHE_STATS_EN
    logic hit_inc_s, miss_inc_s;

    assign hit_inc_s  = (state_r == LOOKUP) && !we_r && hit_s;
    assign miss_inc_s = (state_r == LOOKUP) && !we_r && !hit_s;

    dcache_stat_ctr u_hit_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc_s),
        .count (hit_count)
    );

    dcache_stat_ctr u_miss_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc_s),
        .count (miss_count)
    );
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Cache controller FSM that sits directly upstream of the data_cache array. It drives the array's enable, read/write select, index and write-line inputs, and consumes its combinational tag, valid and data outputs.
- Accepts single-word CPU load/store requests over a valid/ready handshake and performs the tag compare.
- On a read miss, fetches the word from DRAM and fills the line.
- Stores are write-through with write-allocate.

Parameters:
- INDEX_COUNT, 256, number of cache lines; must be a power of 2. Derived localparam IDX_W = $clog2(INDEX_COUNT).
- DATA_W, 32, data word width; one word per line.
- TAG_W, 8, tag width. Derived localparam ADDR_W = TAG_W + IDX_W. Address format: addr = {tag, index}.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_req_valid  in  1  CPU request valid
- cpu_req_ready  out  1  controller can accept a request
- cpu_req_we  in  1  1 = store, 0 = load
- cpu_req_addr  in  ADDR_W  request address
- cpu_req_wdata  in  DATA_W  store data
- cpu_rsp_valid  out  1  one-cycle completion pulse
- cpu_rsp_rdata  out  DATA_W  load data; 0 for stores
- cache_enable  out  1  array enable
- rd_wr_sel  out  1  0 = read, 1 = write
- index_sel  out  IDX_W  array line select
- write_index  out  TAG_W+DATA_W+1  line written as {valid, tag, data}
- cache_valid  in  1  valid bit of the selected line (combinational from the array)
- cache_tag  in  TAG_W  tag of the selected line
- cache_data_io  in  DATA_W  data of the selected line
- mem_req_valid  out  1  DRAM request valid
- mem_req_ready  in  1  DRAM accepts the request
- mem_req_we  out  1  DRAM write
- mem_req_addr  out  ADDR_W  DRAM address
- mem_req_wdata  out  DATA_W  DRAM write data
- mem_rsp_valid  in  1  DRAM read data valid
- mem_rsp_rdata  in  DATA_W  DRAM read data

Behaviour:
- Reset: state IDLE. All outputs 0 except cpu_req_ready, which is 1 from the first cycle after rst deasserts.
- rst asserted mid-operation aborts immediately: no response, any outstanding DRAM transaction is abandoned, and a late mem_rsp_valid is ignored. The array is reset by the same rst.
- Request latch: a request is accepted when cpu_req_valid && cpu_req_ready. addr, we and wdata are latched. cpu_req_ready = 1 only in IDLE.
- index_sel always equals the latched index in non-IDLE states.
- FSM states and transitions:
  - IDLE: on accept -> LOOKUP.
  - LOOKUP: hit = cache_valid && (cache_tag == latched tag).
    - Load hit: capture cache_data_io into rdata -> RESP.
    - Load miss -> MEM_RD.
    - Store (hit or miss) -> WR_CACHE.
  - MEM_RD: mem_req_valid=1, we=0, addr=latched. Hold until mem_req_ready, then -> MEM_WAIT.
  - MEM_WAIT: wait for mem_rsp_valid; capture mem_rsp_rdata -> FILL. mem_rsp_valid outside MEM_WAIT is ignored.
  - FILL: cache_enable=1, rd_wr_sel=1, write_index={1'b1, tag, rdata} for one cycle -> RESP.
  - WR_CACHE: cache_enable=1, rd_wr_sel=1, write_index={1'b1, tag, wdata} for one cycle -> MEM_WR.
  - MEM_WR: mem_req_valid=1, we=1, addr and wdata from the latch. Hold until mem_req_ready -> RESP. Stores complete on DRAM acceptance; there is no write response.
  - RESP: cpu_rsp_valid=1 for exactly one cycle; cpu_rsp_rdata = rdata for loads, 0 for stores -> IDLE.
- cache_enable is 0 in every state except FILL and WR_CACHE.
- mem_req_* outputs are stable while mem_req_valid && !mem_req_ready.
- Latency, with accept in cycle 0:
  - Load hit: rsp_valid in cycle 2.
  - Store with ready tied high: rsp_valid in cycle 4.
  - Load miss with ready high and DRAM latency L: rsp_valid in cycle 4+L.
- Back-to-back: the next request can be accepted in the cycle after RESP.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: adds outputs hit_count and miss_count, each 32 bits wide.
  - Counted in LOOKUP for loads only.
  - Saturate at 2^32-1.
  - Cleared by rst.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- dcache_pkg holds:
  - the state_t enum (IDLE, LOOKUP, MEM_RD, MEM_WAIT, FILL, WR_CACHE, MEM_WR, RESP);
  - the STAT_W=32 constant.
- One sub-module, dcache_stat_ctr: a saturating 32-bit counter, instantiated twice under DCACHE_STATS_EN.

Test Plan:
- Load of 0x012A after reset, DRAM latency 3 returns 0xDEADBEEF:
  - mem_req addr=0x012A, we=0;
  - line 0x2A filled with {1, 0x01, 0xDEADBEEF};
  - rsp rdata=0xDEADBEEF in cycle 7.
- Repeat load of 0x012A: no mem_req; rsp rdata=0xDEADBEEF in cycle 2; hit_count=1, miss_count=1.
- Store 0x5555AAAA to 0x032A: line 0x2A becomes {1, 0x03, 0x5555AAAA}; mem_req we=1 addr=0x032A; rsp rdata=0; a following load of 0x012A misses.
- mem_req_ready held low 5 cycles during MEM_RD: mem_req_valid and addr stable throughout; cpu_req_ready stays 0.
- rst asserted in MEM_WAIT, then mem_rsp_valid arrives: no cache write, no rsp_valid; cpu_req_ready=1 the cycle after rst drops.
- Stray mem_rsp_valid in IDLE: ignored, no state change.
